// File: rtl/braid_seq_if.sv
// Host-side control and valve/enable status bundle for braid_flow_sequencer.
// The sequencer connects through the slave modport; the host drives through master.
interface braid_seq_if #(
  parameter int N_IN    = 4,
  parameter int N_STAGE = 8,
  parameter int DWELL_W = 8
);
  localparam int SIDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  logic               start;
  logic               abort;
  logic [DWELL_W-1:0] fill_cycles;
  logic [DWELL_W-1:0] mix_cycles;
  logic [DWELL_W-1:0] drain_cycles;
  logic [N_IN-1:0]    inlet_valve;
  logic [N_STAGE-1:0] stage_en;
  logic [N_IN-1:0]    outlet_valve;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [SIDX_W-1:0]  stage_idx;

  modport master (
    output start, abort, fill_cycles, mix_cycles, drain_cycles,
    input  inlet_valve, stage_en, outlet_valve, busy, done, aborted, stage_idx
  );

  modport slave (
    input  start, abort, fill_cycles, mix_cycles, drain_cycles,
    output inlet_valve, stage_en, outlet_valve, busy, done, aborted, stage_idx
  );
endinterface

// File: rtl/braid_flow_sequencer.sv
// Fill / mix / drain valve sequencer for the braid mixing network.
// Define BRAID_SEQ_SERIAL_FILL_EN to open inlets one lane at a time instead of all together.
module braid_flow_sequencer #(
  parameter int N_IN    = 4,
  parameter int N_STAGE = 8,
  parameter int DWELL_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  braid_seq_if.slave bus
);
  localparam int SIDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
  localparam int LANE_W = (N_IN > 1) ? $clog2(N_IN) : 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MIX, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] fill_q, fill_d, mix_q, mix_d, drain_q, drain_d;
  logic [SIDX_W-1:0]  stage_q, stage_d;
  logic               abort_q, abort_d;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
  logic [LANE_W-1:0]  lane_q, lane_d;
`endif

  logic [N_IN-1:0]    inlet_q, inlet_d, outlet_q, outlet_d;
  logic [N_STAGE-1:0] stage_en_q, stage_en_d;
  logic [SIDX_W-1:0]  stage_idx_q, stage_idx_d;
  logic               busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  // A zero dwell is treated as one cycle so every phase is visible.
  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] v);
    return (v == '0) ? DWELL_W'(1) : v;
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + DWELL_W'(1);
    fill_d  = fill_q;
    mix_d   = mix_q;
    drain_d = drain_q;
    stage_d = stage_q;
    abort_d = abort_q;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
    lane_d  = lane_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        stage_d = '0;
        abort_d = 1'b0;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
        lane_d  = '0;
`endif
        if (bus.start) begin
          state_d = S_FILL;
          fill_d  = eff_dwell(bus.fill_cycles);
          mix_d   = eff_dwell(bus.mix_cycles);
          drain_d = eff_dwell(bus.drain_cycles);
        end
      end
      S_FILL: begin
        if (bus.abort) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == fill_q - DWELL_W'(1)) begin
          cnt_d = '0;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
          if (lane_q == LANE_W'(N_IN - 1)) begin
            state_d = S_MIX;
            stage_d = '0;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
`else
          state_d = S_MIX;
          stage_d = '0;
`endif
        end
      end
      S_MIX: begin
        if (bus.abort) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == mix_q - DWELL_W'(1)) begin
          cnt_d = '0;
          if (stage_q == SIDX_W'(N_STAGE - 1)) state_d = S_DRAIN;
          else                                 stage_d = stage_q + SIDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == drain_q - DWELL_W'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they change on the same edge as the state.
    inlet_d     = '0;
    stage_en_d  = '0;
    outlet_d    = '0;
    stage_idx_d = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    unique case (state_d)
      S_FILL: begin
`ifdef BRAID_SEQ_SERIAL_FILL_EN
        inlet_d = N_IN'(1) << lane_d;
`else
        inlet_d = '1;
`endif
        busy_d = 1'b1;
      end
      S_MIX: begin
        stage_en_d  = N_STAGE'(1) << stage_d;
        stage_idx_d = stage_d;
        busy_d      = 1'b1;
      end
      S_DRAIN: begin
        outlet_d = '1;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        done_d    = 1'b1;
        aborted_d = abort_d;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fill_q      <= '0;
      mix_q       <= '0;
      drain_q     <= '0;
      stage_q     <= '0;
      abort_q     <= 1'b0;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
      lane_q      <= '0;
`endif
      inlet_q     <= '0;
      stage_en_q  <= '0;
      outlet_q    <= '0;
      stage_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      mix_q       <= mix_d;
      drain_q     <= drain_d;
      stage_q     <= stage_d;
      abort_q     <= abort_d;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
      lane_q      <= lane_d;
`endif
      inlet_q     <= inlet_d;
      stage_en_q  <= stage_en_d;
      outlet_q    <= outlet_d;
      stage_idx_q <= stage_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.inlet_valve  = inlet_q;
  assign bus.stage_en     = stage_en_q;
  assign bus.outlet_valve = outlet_q;
  assign bus.stage_idx    = stage_idx_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
endmodule

// File: tb/tb_braid_flow_sequencer.sv
// Directed self-checking bench for braid_flow_sequencer; expected outputs come from the
// cycle schedule in the timing description (valid with or without BRAID_SEQ_SERIAL_FILL_EN).
module tb_braid_flow_sequencer;
  localparam int N_IN = 4, N_STAGE = 8, DWELL_W = 8;
`ifdef BRAID_SEQ_SERIAL_FILL_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   seen;

  braid_seq_if #(.N_IN(N_IN), .N_STAGE(N_STAGE), .DWELL_W(DWELL_W)) bus ();

  braid_flow_sequencer #(.N_IN(N_IN), .N_STAGE(N_STAGE), .DWELL_W(DWELL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] out_vec();
    return {bus.inlet_valve, bus.stage_en, bus.outlet_valve,
            bus.busy, bus.done, bus.aborted, bus.stage_idx};
  endfunction

  // Expected outputs in cycle c of a run whose start was sampled in cycle 0.
  function automatic logic [21:0] model(int c, int fe, int me, int de, int ac);
    logic [3:0] in_v = '0, out_v = '0;
    logic [7:0] se = '0;
    logic [2:0] idx = '0;
    logic b = 1'b0, dn = 1'b0, ab = 1'b0;
    int p, ds, dc, k;
    p  = SERIAL ? N_IN * fe : fe;
    ds = (ac > 0) ? ac + 1 : p + N_STAGE * me + 1;
    dc = ds + de;
    if (c >= 1 && c < ds) begin
      b = 1'b1;
      if (c <= p) begin
        in_v = SERIAL ? 4'(1 << ((c - 1) / fe)) : 4'hF;
      end else begin
        k   = (c - p - 1) / me;
        se  = 8'(1 << k);
        idx = 3'(k);
      end
    end else if (c >= ds && c < dc) begin
      out_v = 4'hF;
      b     = 1'b1;
    end else if (c == dc) begin
      dn = 1'b1;
      ab = (ac > 0);
    end
    return {in_v, se, out_v, b, dn, ab, idx};
  endfunction

  // One run from the current (idle) cycle; checks every cycle through the first idle cycle after done.
  task automatic run(input string name, input int f, input int m, input int d, input int ac,
                     input bit abort0, input bit hold, input bit perturb, output int done_seen);
    int fe, me, de, p, dc;
    fe = (f == 0) ? 1 : f;
    me = (m == 0) ? 1 : m;
    de = (d == 0) ? 1 : d;
    p  = SERIAL ? N_IN * fe : fe;
    dc = ((ac > 0) ? ac + 1 : p + N_STAGE * me + 1) + de;
    bus.fill_cycles  = 8'(f);
    bus.mix_cycles   = 8'(m);
    bus.drain_cycles = 8'(d);
    bus.start        = 1'b1;
    bus.abort        = abort0;
    done_seen        = -1;
    for (int c = 1; c <= dc + 1; c++) begin
      step();
      bus.start = hold;
      bus.abort = (c == ac);
      if (perturb && c == 2) begin
        bus.start        = 1'b1;
        bus.fill_cycles  = 8'd7;
        bus.mix_cycles   = 8'd5;
        bus.drain_cycles = 8'd9;
      end
      check($sformatf("%s_c%0d", name, c), 32'(out_vec()), 32'(model(c, fe, me, de, ac)));
      if (bus.done === 1'b1) done_seen = c;
    end
    if (hold) begin
      step();
      check($sformatf("%s_refill", name), {27'd0, bus.inlet_valve, bus.busy},
            {27'd0, (SERIAL ? 4'h1 : 4'hF), 1'b1});
      bus.start = 1'b0;
    end
  endtask

  initial begin
    int p;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.fill_cycles  = '0;
    bus.mix_cycles   = '0;
    bus.drain_cycles = '0;
    step();
    step();
    check("reset_outputs", 32'(out_vec()), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_outputs", 32'(out_vec()), 32'd0);

    run("basic", 3, 2, 4, 0, 1'b0, 1'b0, 1'b0, seen);
    check("basic_done_cycle", 32'(seen), SERIAL ? 32'd33 : 32'd24);

    run("serial_plan", 2, 1, 1, 0, 1'b0, 1'b0, 1'b0, seen);
    check("serial_plan_done_cycle", 32'(seen), SERIAL ? 32'd18 : 32'd12);

    run("zero", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, seen);
    check("zero_done_cycle", 32'(seen), SERIAL ? 32'd14 : 32'd11);

    // Abort sampled in the first cycle of stage 3.
    p = SERIAL ? 12 : 3;
    run("abort_mix", 3, 2, 5, p + 7, 1'b0, 1'b0, 1'b0, seen);
    check("abort_mix_done_cycle", 32'(seen), SERIAL ? 32'd25 : 32'd16);

    // Start and abort together in idle: abort ignored there, but still high in cycle 1 aborts.
    run("start_abort", 4, 4, 2, 1, 1'b1, 1'b0, 1'b0, seen);
    check("start_abort_done_cycle", 32'(seen), 32'd4);

    run("max_dwell", 255, 1, 255, 0, 1'b0, 1'b0, 1'b0, seen);
    check("max_dwell_done_cycle", 32'(seen), SERIAL ? 32'd1284 : 32'd519);

    run("hold_perturb", 2, 3, 2, 0, 1'b0, 1'b1, 1'b1, seen);
    check("hold_perturb_done_cycle", 32'(seen), SERIAL ? 32'd35 : 32'd29);

    // Clear the back-to-back run left in progress.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("reset_between", 32'(out_vec()), 32'd0);

    // Asynchronous reset while draining.
    p = SERIAL ? 4 : 1;
    bus.fill_cycles  = 8'd1;
    bus.mix_cycles   = 8'd1;
    bus.drain_cycles = 8'd6;
    bus.start        = 1'b1;
    for (int c = 1; c <= p + 10; c++) begin
      step();
      bus.start = 1'b0;
      check($sformatf("pre_rst_c%0d", c), 32'(out_vec()), 32'(model(c, 1, 1, 6, 0)));
    end
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", 32'(out_vec()), 32'd0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("post_rst_c%0d", c), 32'(out_vec()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/braid_flow_sequencer.md
# braid_flow_sequencer

Cycle-accurate valve and mixer-enable sequencer for a braid mixing network with `N_IN` lanes and `N_STAGE` mixer stages.
- On `start` it runs four phases, then returns to idle:
  - opens the inlet valves;
  - enables the mixer stages one at a time;
  - opens the outlet valves to drain;
  - pulses `done`.
- It sits between the host protocol controller and the fluidic netlist.
- It is the driving side of the braid: it produces the control stimulus that the passive mixer network only consumes.

## Interface
Parameters:
- `N_IN`, 4, number of inlet and outlet lanes.
- `N_STAGE`, 8, number of mixer stages, enabled in order.
- `DWELL_W`, 8, width of the dwell-count inputs.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; level-sampled and accepted only in IDLE.
- `abort`  in  1  abort request; jumps to DRAIN from FILL or MIX.
- `fill_cycles`  in  `DWELL_W`  dwell for the FILL phase.
- `mix_cycles`  in  `DWELL_W`  dwell per mixer stage.
- `drain_cycles`  in  `DWELL_W`  dwell for the DRAIN phase.
- `inlet_valve`  out  `N_IN`  inlet valve opens.
- `stage_en`  out  `N_STAGE`  one-hot mixer stage enable.
- `outlet_valve`  out  `N_IN`  outlet valve opens.
- `busy`  out  1  high during FILL, MIX and DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: run ended by `abort`.
- `stage_idx`  out  `$clog2(N_STAGE)`  index of the current mixer stage.

## Operation
- FSM states: IDLE, FILL, MIX, DRAIN, DONE. All outputs are registered.
- Reset values: state IDLE, all outputs 0, internal counters 0, sticky abort flag 0.
- Dwell inputs:
  - Latched at start acceptance; changes during a run have no effect.
  - An effective dwell is max(value, 1), so a value of 0 behaves as 1.
- IDLE:
  - All valves and stage enables are 0.
  - `start`=1 → FILL.
  - `abort` is ignored.
- FILL:
  - `inlet_valve` pattern is set by the configuration macro (see Configuration).
  - On dwell expiry → MIX with stage 0.
- MIX:
  - `stage_en` = 1<<k, `stage_idx` = k, each stage held M cycles.
  - After stage `N_STAGE`-1 → DRAIN.
  - Inlets and outlets are 0.
- DRAIN:
  - `outlet_valve` = all ones for D cycles; other outputs 0.
  - → DONE.
  - `abort` is ignored.
- DONE:
  - `done`=1 for exactly one cycle; `aborted`=1 in that same cycle if the run was aborted.
  - → IDLE.
  - `busy`=0.
- Abort:
  - `abort`=1 sampled in FILL or MIX → DRAIN next cycle with the full D dwell, and the sticky abort flag is set.
  - The sticky flag clears on return to IDLE.
- Mutual exclusion: the inlet, stage and outlet output groups are never asserted in the same cycle, including across a phase transition.
- Asynchronous reset mid-run: all valves and enables close immediately, regardless of clock; no `done` pulse is produced.

## Timing
- Notation:
  - `start` is sampled high in cycle 0.
  - F, M and D are the effective fill, mix and drain dwells.
  - P = F (parallel fill) or `N_IN`·F (sequential fill).
- Phase cycles:
  - FILL: cycles 1..P.
  - MIX: cycles P+1..P+`N_STAGE`·M.
  - DRAIN: the next D cycles.
  - `done` in cycle P+`N_STAGE`·M+D+1.
- `busy` rises in cycle 1 and falls in the DONE cycle.
- Earliest next accepted `start`: the cycle after DONE, i.e. the first IDLE cycle.
- `start` held high continuously → back-to-back runs separated by exactly one IDLE cycle.
- `start` and `abort` high together in IDLE → start accepted, abort ignored. If `abort` is still high in cycle 1 it aborts, and DRAIN begins in cycle 2.
- Abort sampled in cycle c → `inlet_valve`/`stage_en` are 0 in cycle c+1; DRAIN covers c+1..c+D; `done`=`aborted`=1 in cycle c+D+1.
- Counter width: dwell counters are `DWELL_W` bits. The value 2^`DWELL_W`−1 gives the maximum dwell, with no wrap artefacts.

## Configuration
- `BRAID_SEQ_SERIAL_FILL_EN` defined:
  - FILL opens one inlet at a time: lane i is open for F cycles, in lane order 0..`N_IN`-1.
  - `inlet_valve` is one-hot and P = `N_IN`·F.
  - Abort during FILL closes the current lane immediately.
- `BRAID_SEQ_SERIAL_FILL_EN` undefined:
  - All inlets open together for F cycles; `inlet_valve` = all ones, P = F.

## Test plan
- Parallel fill (macro off), fill=3, mix=2, drain=4, `start` in cycle 0:
  - `inlet_valve`=4'hF in cycles 1–3;
  - `stage_en` steps 0x01→0x80, 2 cycles each, over cycles 4–19;
  - `outlet_valve`=4'hF in cycles 20–23;
  - `done`=1, `aborted`=0 in cycle 24.
- Serial fill (macro on), fill=2, mix=1, drain=1:
  - `inlet_valve` = 1,1,2,2,4,4,8,8 over cycles 1–8;
  - MIX over cycles 9–16; DRAIN in cycle 17; `done` in cycle 18.
- Zero dwells (all three 0, macro off): FILL 1 cycle, each stage 1 cycle, DRAIN 1 cycle, `done` in cycle 11.
- Abort in MIX at stage 3, with drain=5:
  - the next cycle shows `stage_en`=0 and `outlet_valve`=4'hF for 5 cycles;
  - then `done`=`aborted`=1 for one cycle.
- `start` re-asserted mid-run and `dwell` inputs changed mid-run: no effect on phase lengths; `start` held high → next FILL begins exactly 2 cycles after `done`.
- Assert `rst_n`=0 asynchronously mid-DRAIN: all outputs go to 0 before the next clock edge; after release, state is IDLE and no `done` pulse occurs.
